// File: rtl/vga_capture.sv
// vga_capture: synchronizes a 3-3-2 VGA stream, locks onto its timing and emits captured pixels with coordinates.
// Ports: CLK_50/RST (sync, active-high); h_sync/v_sync (active-low) and RED/GREEN/BLUE asynchronous inputs;
// pix_data/pix_x/pix_y/pix_valid/frame_start capture outputs, locked timing indicator, frame_sum checksum.
// Optional feature: define VGA_CAPTURE_CHECKSUM_EN for the per-frame pix_data sum on frame_sum (otherwise 0).
module vga_capture #(
  parameter int H_TOTAL = 1600,
  parameter int V_TOTAL = 525,
  parameter int H_START = 288,
  parameter int V_START = 35,
  parameter int H_VIS   = 640,
  parameter int V_VIS   = 480
) (
  input  logic        CLK_50,
  input  logic        RST,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [2:0]  RED,
  input  logic [2:0]  GREEN,
  input  logic [1:0]  BLUE,
  output logic [7:0]  pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [15:0] frame_sum
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state, state_nx;
  logic [1:0] hs_s, vs_s;
  logic [7:0] d1, d2;
  logic h_prev, v_prev, h_fall, v_fall, line_err, frame_err, err, sample;
  logic [11:0] h_cnt;
  logic [9:0] v_cnt, v_off;
  logic [10:0] h_off;
  // syncs and data share one two-flop pipeline so colour stays aligned with the sync edges
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      hs_s <= 2'b11;
      vs_s <= 2'b11;
      h_prev <= 1'b1;
      v_prev <= 1'b1;
      d1 <= '0;
      d2 <= '0;
    end else begin
      hs_s <= {hs_s[0], h_sync};
      vs_s <= {vs_s[0], v_sync};
      h_prev <= hs_s[1];
      v_prev <= vs_s[1];
      d1 <= {RED, GREEN, BLUE};
      d2 <= d1;
    end
  end
  assign h_fall = !hs_s[1] && h_prev;
  assign v_fall = !vs_s[1] && v_prev;
  assign line_err = h_fall && (int'(h_cnt) + 1 != H_TOTAL);
  assign frame_err = v_fall && (int'(v_cnt) + 1 != V_TOTAL);
  assign h_off = 11'(h_cnt - 12'(H_START));
  assign v_off = v_cnt - 10'(V_START);
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_fall ? 12'd0 : (h_cnt == 12'hFFF ? h_cnt : h_cnt + 12'd1);
      v_cnt <= v_fall ? 10'd0 : (h_fall ? v_cnt + 10'd1 : v_cnt);
    end
  end
  always_comb begin
    state_nx = state;
    sample = 1'b0;
    state_nx = state == SEARCH ? (v_fall ? MEASURE : SEARCH) :
               state == MEASURE ? (v_fall && !(err || line_err || frame_err) ? LOCKED : MEASURE) :
               (line_err || frame_err || h_cnt == 12'hFFF) ? SEARCH : LOCKED;
    sample = state == LOCKED && int'(v_cnt) >= V_START && int'(v_cnt) < V_START + V_VIS &&
             int'(h_cnt) >= H_START && int'(h_cnt) < H_START + 2 * H_VIS && !h_off[0];
  end
  // err remembers any bad line seen while measuring; it restarts on each v_sync fall
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state <= SEARCH;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      err <= (state == MEASURE && !v_fall) ? (err || line_err) : 1'b0;
    end
  end
  assign locked = state == LOCKED;
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      pix_valid <= 1'b0;
      frame_start <= 1'b0;
      pix_data <= '0;
      pix_x <= '0;
      pix_y <= '0;
    end else begin
      pix_valid <= sample;
      frame_start <= sample && h_off == 11'd0 && v_off == 10'd0;
      if (sample) begin
        pix_data <= d2;
        pix_x <= h_off[10:1];
        pix_y <= v_off;
      end
    end
  end
`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [15:0] acc, acc_nx;
  assign acc_nx = (frame_start ? 16'd0 : acc) + {8'd0, pix_data};
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      acc <= '0;
      frame_sum <= '0;
    end else if (pix_valid) begin
      acc <= acc_nx;
      if (pix_x == 10'(H_VIS - 1) && pix_y == 10'(V_VIS - 1)) frame_sum <= acc_nx;
    end
  end
`else
  assign frame_sum = '0;
`endif
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: frame-level scenario table with random images against a raster-order capture model.
module tb_vga_capture;
  localparam int HT = 40, VT = 12, HS = 6, VS = 2, HV = 12, VV = 6, HSW = 4;
  localparam int RX = 6, RY = 3;
  logic clk = 0, rst = 1, h_sync = 1, v_sync = 1;
  logic [2:0] red = 0, green = 0;
  logic [1:0] blue = 0;
  logic [7:0] pix_data;
  logic [9:0] pix_x, pix_y;
  logic pix_valid, frame_start, locked;
  logic [15:0] frame_sum;
  always #5 clk = ~clk;
  vga_capture #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS), .H_VIS(HV), .V_VIS(VV)) dut (
    .CLK_50(clk), .RST(rst), .h_sync(h_sync), .v_sync(v_sync), .RED(red), .GREEN(green), .BLUE(blue),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .frame_start(frame_start),
    .locked(locked), .frame_sum(frame_sum));
  typedef struct {int mode; int err; int exp_lock; int exp_pix;} row_t;
  typedef struct {int x; int y; int d; int fs;} pix_t;
  pix_t cap[$];
  logic [7:0] img [VV][HV];
  row_t rows [15];
  int total = 0, bad = 0, hold_err = 0;
  logic [7:0] last_d = 0;
  logic [9:0] last_x = 0, last_y = 0;
  logic rst_d = 1;
  always @(posedge clk) rst_d <= rst;
  always @(negedge clk) begin
    if (rst_d) begin
      last_d = 0;
      last_x = 0;
      last_y = 0;
    end
    if (pix_valid) begin
      cap.push_back('{int'(pix_x), int'(pix_y), int'(pix_data), int'(frame_start)});
      last_d = pix_data;
      last_x = pix_x;
      last_y = pix_y;
    end else if ({pix_x, pix_y, pix_data} !== {last_x, last_y, last_d} || frame_start !== 1'b0) hold_err++;
  end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " pix_valid"}, int'(pix_valid), 0);
    chk({tag, " pix_x"}, int'(pix_x), 0);
    chk({tag, " pix_y"}, int'(pix_y), 0);
    chk({tag, " pix_data"}, int'(pix_data), 0);
    chk({tag, " frame_start"}, int'(frame_start), 0);
    chk({tag, " locked"}, int'(locked), 0);
    chk({tag, " frame_sum"}, int'(frame_sum), 0);
  endtask
  task automatic fill(input int mode);
    for (int y = 0; y < VV; y++)
      for (int x = 0; x < HV; x++)
        img[y][x] = mode == 0 ? 8'hE3 : mode == 1 ? 8'($urandom) :
                    mode == 2 ? ((x >= 3 && x <= 7 && y >= 2 && y <= 4) ? 8'hFF : 8'h00) : 8'h01;
  endtask
  task automatic run_frame(input row_t r, input int idx);
    int len, n, mism, sum;
    string tag;
    tag = $sformatf("row%0d", idx);
    cap.delete();
    hold_err = 0;
    for (int l = 0; l < VT; l++) begin
      len = (r.err == 1 && l == VS + 2) ? HT - 2 : (r.err == 2 && l == VS + 1) ? 4200 : HT;
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        if (r.err == 3 && l == VS + RY && i == HS + 2 * RX + 1) chk_zero({tag, " after_rst"});
        rst = r.err == 3 && l == VS + RY && i == HS + 2 * RX;
        h_sync = !(i < HSW);
        v_sync = !(l < 2);
        if (l >= VS && l < VS + VV && i >= HS && i < HS + 2 * HV) {red, green, blue} = img[l - VS][(i - HS) / 2];
        else {red, green, blue} = 8'h00;
      end
    end
    n = r.exp_pix < 0 ? HV * VV : r.exp_pix;
    chk({tag, " locked"}, int'(locked), r.exp_lock);
    chk({tag, " pix_count"}, cap.size(), n);
    mism = 0;
    sum = 0;
    foreach (cap[k])
      if (cap[k].x != k % HV || cap[k].y != k / HV || k >= HV * VV ||
          cap[k].d != int'(img[(k / HV) % VV][k % HV]) || cap[k].fs != int'(k == 0)) mism++;
    chk({tag, " pixel_mismatches"}, mism, 0);
    chk({tag, " hold_violations"}, hold_err, 0);
    if (r.exp_pix < 0) begin
`ifdef VGA_CAPTURE_CHECKSUM_EN
      for (int y = 0; y < VV; y++) for (int x = 0; x < HV; x++) sum += int'(img[y][x]);
      sum = sum % 65536;
`endif
      chk({tag, " frame_sum"}, int'(frame_sum), sum);
    end
  endtask
  initial begin
    rows = '{'{0, 0, 0, 0}, '{0, 0, 1, -1}, '{0, 0, 1, -1}, '{1, 0, 1, -1}, '{1, 1, 0, 3 * HV},
             '{1, 0, 0, 0}, '{1, 0, 1, -1}, '{2, 0, 1, -1}, '{1, 2, 0, 2 * HV}, '{1, 0, 0, 0},
             '{3, 0, 1, -1}, '{1, 3, 0, RY * HV + RX - 1}, '{1, 0, 0, 0}, '{1, 0, 1, -1}, '{1, 0, 1, -1}};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    for (int f = 0; f < 15; f++) begin
      fill(rows[f].mode);
      run_frame(rows[f], f);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_TOTAL, default 1600, is the expected line length in CLK_50 cycles (800 pixels at 2 clocks each).
REQ-002 Parameter V_TOTAL, default 525, is the expected lines per frame.
REQ-003 Parameter H_START, default 288, is the clock offset from h_sync falling edge to the first visible pixel (96+48 pixels x2).
REQ-004 Parameter V_START, default 35, is the line index of the first visible line (vsync line = 0).
REQ-005 Parameter H_VIS, default 640, is the number of visible pixels per line.
REQ-006 Parameter V_VIS, default 480, is the number of visible lines per frame.
REQ-007 CLK_50  in  1  sole clock, 50 MHz.
REQ-008 RST  in  1  reset, synchronous, active-high.
REQ-009 h_sync, v_sync  in  1 each  asynchronous, active-low syncs.
REQ-010 RED in 3, GREEN in 3, BLUE in 2  asynchronous pixel colour.
REQ-011 pix_data  out  8  captured pixel {RED,GREEN,BLUE}.
REQ-012 pix_x, pix_y  out  10 each  coordinate of pix_data.
REQ-013 pix_valid  out  1  one-cycle strobe per captured pixel.
REQ-014 frame_start  out  1  strobe coincident with pix_valid at (0,0).
REQ-015 locked  out  1  timing lock indicator.
REQ-016 frame_sum  out  16  per-frame checksum (see Configuration).

Function
REQ-017 All eight data bits and both syncs SHALL pass through an identical 2-flop synchronizer, preserving mutual alignment.
REQ-018 Sync fall: synchronized sync low while its prior registered value was high; one-cycle event.
REQ-019 h_cnt (12 bit) SHALL clear to 0 on h_sync fall, else increment, saturating at 4095.
REQ-020 v_cnt (10 bit) SHALL clear to 0 on v_sync fall, else increment on h_sync fall; coincident events: v_sync clear wins.
REQ-021 Line-length error: at h_sync fall, h_cnt+1 != H_TOTAL; frame error: at v_sync fall, v_cnt+1 != V_TOTAL.
REQ-022 FSM SEARCH -> MEASURE on v_sync fall.
REQ-023 MEASURE -> LOCKED on v_sync fall if no line-length error since entering MEASURE and no frame error, else remain MEASURE (error flag cleared).
REQ-024 LOCKED -> SEARCH on any line-length error, frame error, or h_cnt reaching 4095; locked=1 only in LOCKED.
REQ-025 Sample point: LOCKED, V_START <= v_cnt < V_START+V_VIS, H_START <= h_cnt < H_START+2*H_VIS, (h_cnt-H_START) even.
REQ-026 At a sample point, next cycle: pix_valid=1, pix_data=synchronized RGB, pix_x=(h_cnt-H_START)>>1, pix_y=v_cnt-V_START; pix_valid=0 otherwise.
REQ-027 Input-to-output latency SHALL be fixed at 3 CLK_50 cycles (2 synchronizer + 1 output register).
REQ-028 pix_x, pix_y, pix_data SHALL hold their last values while pix_valid=0.
REQ-029 Lock loss mid-line SHALL suppress pix_valid from the next cycle; no partial-frame resumption until LOCKED again.

Reset
REQ-030 RST SHALL force FSM=SEARCH, h_cnt=v_cnt=0, synchronizer sync flops=1, data flops=0, and all outputs to 0.
REQ-031 RST asserted mid-frame SHALL take effect on the next CLK_50 edge; relock requires two further v_sync falls.

Configuration
REQ-032 Macro VGA_CAPTURE_CHECKSUM_EN defined: 16-bit wrap-around sum of pix_data over all pix_valid cycles of a frame, copied to frame_sum on the cycle after the last visible pixel (639,479); accumulator cleared on frame_start (sum restarts with that pixel).
REQ-033 Macro undefined: frame_sum tied to 0, no accumulator logic.

Verification
REQ-034 Reset then two clean 640x480 frames of constant 8'hE3 -> locked=1 after 2nd v_sync fall; third frame: 307200 pix_valid, all pix_data=8'hE3.
REQ-035 Locked; one line of 1598 clocks -> locked=0 within 1 cycle of that h_sync fall; no pix_valid until relock.
REQ-036 Locked; white box at pixels x 100..300, y 101..299 on black -> pix_data=8'hFF exactly at those coordinates, 8'h00 elsewhere.
REQ-037 Locked; h_sync held high 4096 clocks -> locked=0, FSM SEARCH.
REQ-038 CHECKSUM_EN, frame of constant 8'h01 -> frame_sum=16'hB000 (307200 mod 65536); undefined -> frame_sum=0.
REQ-039 RST pulsed at pixel (320,240) -> all outputs 0 next cycle; locked again after 2 clean frames.
